// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared definitions for the pipeline hazard scoreboard:
//   - forward-select encodings driven on the fwd_* outputs
//   - default mul/div latencies
//   - mul/div busy-counter state encoding
//   - a helper that resolves the nearest-stage forward priority
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Nearest stage wins: a matching M writer shadows W even when its result is
  // not ready yet, because W would then hold an older value of the register.
  function automatic logic [1:0] fwd_pick(input logic m_hit, input logic m_rdy,
                                          input logic w_hit, input logic w_rdy);
    if (m_hit) return m_rdy ? FWD_M : FWD_NONE;
    if (w_hit) return w_rdy ? FWD_W : FWD_NONE;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_ctr.sv
// -----------------------------------------------------------------------------
// md_busy_ctr
//   Busy counter for the multi-cycle mul/div unit. A load starts a count of
//   MUL_LAT or DIV_LAT cycles; busy is high while the count is non-zero.
// Ports
//   clk    in  clock
//   reset  in  synchronous, active-high; aborts any count in progress
//   load   in  a mult/div leaves D this cycle
//   div    in  1: load DIV_LAT, 0: load MUL_LAT
//   busy   out counter non-zero
// -----------------------------------------------------------------------------
module md_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CW      = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state. A load while busy cannot occur: the top stalls any mul/div
  // in D while busy, and only an unstalled one produces load.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      MD_IDLE: begin
        if (load) begin
          state_d = MD_BUSY;
          count_d = div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end
      end
      MD_BUSY: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Outputs.
  always_comb busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard controller for a 5-stage F/D/E/M/W pipeline with a multi-cycle
//   mul/div unit. Tracks a shadow copy of the writer info in E/M/W, decides
//   stalls from the Tuse/Tnew rule and produces forwarding selects.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   rs_d, rt_d                 D-stage source registers
//   tuse_rs_d, tuse_rt_d       cycles until operand needed; all-ones = unused
//   waddr_d, tnew_d            D destination and its Tnew (0 = no write)
//   md_op_d, md_div_d          D is mult/div; div selects DIV_LAT
//   md_use_d                   D is mfhi/mflo/mthi/mtlo
//   stall_pc, stall_d, flush_e hold PC and F/D, bubble into D/E
//   fwd_rs_d ... fwd_rt_e      00 none, 01 from M, 10 from W
//   fwd_rt_m                   store data forwarded from W
//   md_busy                    mul/div unit busy
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int T_W     = 2,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [T_W-1:0]    tuse_rs_d,
  input  logic [T_W-1:0]    tuse_rt_d,
  input  logic [REG_AW-1:0] waddr_d,
  input  logic [T_W-1:0]    tnew_d,
  input  logic              md_op_d,
  input  logic              md_div_d,
  input  logic              md_use_d,
  output logic              stall_pc,
  output logic              stall_d,
  output logic              flush_e,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              md_busy
);

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic              we;
    logic [T_W-1:0]    tnew;
  } writer_t;

  localparam writer_t        BUBBLE = '0;
  localparam logic [T_W-1:0] T_NONE = '1;

  writer_t           e_q, m_q, w_q;
  // Source registers are kept only where a forward still lands on them.
  logic [REG_AW-1:0] e_rs_q, e_rt_q, m_rt_q;

  logic data_stall, md_stall, stall, md_load;

  function automatic logic hit(input writer_t x, input logic [REG_AW-1:0] r);
    return x.we && (x.addr == r) && (r != '0);
  endfunction

  function automatic writer_t age(input writer_t x);
    writer_t y;
    y      = x;
    y.tnew = (x.tnew != '0) ? x.tnew - T_W'(1) : '0;
    return y;
  endfunction

  function automatic logic op_late(input writer_t e, input writer_t m,
                                   input logic [REG_AW-1:0] r,
                                   input logic [T_W-1:0] tuse);
    if (tuse == T_NONE) return 1'b0;
    if (hit(e, r))      return e.tnew > tuse;
    if (hit(m, r))      return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_sel(input writer_t m, input writer_t w,
                                         input logic [REG_AW-1:0] r);
    return fwd_pick(hit(m, r), m.tnew == '0, hit(w, r), w.tnew == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Shadow pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset clears every shadow register; these are a handful of flops,
    // not a memory, and a stale writer after reset would fake a hazard.
    if (reset) begin
      e_q    <= BUBBLE;
      m_q    <= BUBBLE;
      w_q    <= BUBBLE;
      e_rs_q <= '0;
      e_rt_q <= '0;
      m_rt_q <= '0;
    end else begin
      // NOTE: non-blocking so M/W take the pre-edge E/M values (a true shift).
      if (stall) begin
        e_q    <= BUBBLE;
        e_rs_q <= '0;
        e_rt_q <= '0;
      end else begin
        e_q    <= '{addr: waddr_d, we: (tnew_d != '0), tnew: tnew_d};
        e_rs_q <= rs_d;
        e_rt_q <= rt_d;
      end
      m_q    <= age(e_q);
      m_rt_q <= e_rt_q;
      w_q    <= age(m_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Data stall rule
  // ---------------------------------------------------------------------------
  generate
    if (FWD_EN) begin : g_fwd_stall
      always_comb begin
        data_stall = op_late(e_q, m_q, rs_d, tuse_rs_d) |
                     op_late(e_q, m_q, rt_d, tuse_rt_d);
      end
    end else begin : g_nofwd_stall
      // Without forwarding the operand must come from the register file, so
      // any in-flight writer of it blocks D until it has retired.
      always_comb begin
        data_stall = 1'b0;
        if (tuse_rs_d != T_NONE && (hit(e_q, rs_d) || hit(m_q, rs_d) || hit(w_q, rs_d)))
          data_stall = 1'b1;
        if (tuse_rt_d != T_NONE && (hit(e_q, rt_d) || hit(m_q, rt_d) || hit(w_q, rt_d)))
          data_stall = 1'b1;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Mul/div busy tracking; busy is registered, so no loop through stall.
  // ---------------------------------------------------------------------------
  assign md_stall = (md_op_d | md_use_d) & md_busy;
  assign stall    = data_stall | md_stall;
  assign md_load  = md_op_d & ~stall;

  md_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (md_load),
    .div   (md_div_d),
    .busy  (md_busy)
  );

  // ---------------------------------------------------------------------------
  // Outputs. One stall drives all three controls, so a cycle with both a data
  // and a mul/div hazard still inserts a single bubble.
  // ---------------------------------------------------------------------------
  assign stall_pc = stall;
  assign stall_d  = stall;
  assign flush_e  = stall;

  assign fwd_rs_d = FWD_EN ? fwd_sel(m_q, w_q, rs_d)   : FWD_NONE;
  assign fwd_rt_d = FWD_EN ? fwd_sel(m_q, w_q, rt_d)   : FWD_NONE;
  assign fwd_rs_e = FWD_EN ? fwd_sel(m_q, w_q, e_rs_q) : FWD_NONE;
  assign fwd_rt_e = FWD_EN ? fwd_sel(m_q, w_q, e_rt_q) : FWD_NONE;
  assign fwd_rt_m = FWD_EN & hit(w_q, m_rt_q) & (w_q.tnew == '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Two instances (forwarding on / off) each run the same instruction program.
//   A driver per instance issues instructions, holding a stalled one in D, and
//   pushes the model's expected outputs into a queue; a monitor pops and
//   compares on the falling edge.
//   The model keeps the last three instructions that entered E, indexed by
//   age, derives Tnew arithmetically from age, and tracks mul/div busy as the
//   last cycle of the running operation.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int TW  = 2;
  localparam int MUL = 5;
  localparam int DIV = 10;

  typedef struct {
    bit rst;
    bit hold;
    int rs, tuse_rs, rt, tuse_rt, waddr, tnew;
    bit md_op, md_div, md_use;
  } instr_t;

  typedef struct {
    int cyc;
    bit stall;
    int fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    bit fwd_rt_m;
    bit md_busy;
  } exp_t;

  typedef struct {
    bit v;
    int addr, tnew0, rs, rt;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset     [2];
  logic [AW-1:0] rs_d      [2];
  logic [AW-1:0] rt_d      [2];
  logic [AW-1:0] waddr_d   [2];
  logic [TW-1:0] tuse_rs_d [2];
  logic [TW-1:0] tuse_rt_d [2];
  logic [TW-1:0] tnew_d    [2];
  logic          md_op_d   [2];
  logic          md_div_d  [2];
  logic          md_use_d  [2];
  logic          stall_pc  [2];
  logic          stall_d   [2];
  logic          flush_e   [2];
  logic [1:0]    fwd_rs_d  [2];
  logic [1:0]    fwd_rt_d  [2];
  logic [1:0]    fwd_rs_e  [2];
  logic [1:0]    fwd_rt_e  [2];
  logic          fwd_rt_m  [2];
  logic          md_busy   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_scoreboard #(
      .REG_AW  (AW),
      .T_W     (TW),
      .MUL_LAT (MUL),
      .DIV_LAT (DIV),
      .FWD_EN  (g == 0)
    ) dut (
      .clk       (clk),
      .reset     (reset[g]),
      .rs_d      (rs_d[g]),
      .rt_d      (rt_d[g]),
      .tuse_rs_d (tuse_rs_d[g]),
      .tuse_rt_d (tuse_rt_d[g]),
      .waddr_d   (waddr_d[g]),
      .tnew_d    (tnew_d[g]),
      .md_op_d   (md_op_d[g]),
      .md_div_d  (md_div_d[g]),
      .md_use_d  (md_use_d[g]),
      .stall_pc  (stall_pc[g]),
      .stall_d   (stall_d[g]),
      .flush_e   (flush_e[g]),
      .fwd_rs_d  (fwd_rs_d[g]),
      .fwd_rt_d  (fwd_rt_d[g]),
      .fwd_rs_e  (fwd_rs_e[g]),
      .fwd_rt_e  (fwd_rt_e[g]),
      .fwd_rt_m  (fwd_rt_m[g]),
      .md_busy   (md_busy[g])
    );
  end

  int     tests = 0;
  int     fails = 0;
  instr_t prog[$];
  exp_t   exp_q[2][$];

  // Reference model state, per instance. pipe[i][a] = instruction that entered
  // E a cycles ago (0 = in E, 1 = in M, 2 = in W).
  ent_t pipe[2][3];
  int   md_end[2];
  int   cyc[2];

  function automatic int eff(int i, int a);
    return (pipe[i][a].tnew0 > a) ? pipe[i][a].tnew0 - a : 0;
  endfunction

  function automatic bit hits(int i, int a, int r);
    return pipe[i][a].v && pipe[i][a].addr == r && r != 0;
  endfunction

  // Nearest producer in M or W; code equals its age (1 = M, 2 = W).
  function automatic int pick(int i, int r);
    for (int a = 1; a <= 2; a++)
      if (hits(i, a, r)) return (eff(i, a) == 0) ? a : 0;
    return 0;
  endfunction

  function automatic bit op_stall(int i, int r, int tuse);
    if (tuse == 3) return 0;
    if (i == 1) begin
      for (int a = 0; a <= 2; a++) if (hits(i, a, r)) return 1;
      return 0;
    end
    for (int a = 0; a <= 1; a++) if (hits(i, a, r)) return eff(i, a) > tuse;
    return 0;
  endfunction

  function automatic instr_t mk(int rs, int tr, int rt, int tt, int wa, int tn,
                                bit op, bit dv, bit us, bit hold);
    instr_t s;
    s = '{rst: 1'b0, hold: hold, rs: rs, tuse_rs: tr, rt: rt, tuse_rt: tt,
          waddr: wa, tnew: tn, md_op: op, md_div: dv, md_use: us};
    return s;
  endfunction

  function automatic instr_t nop();
    return mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic instr_t rst_cycle();
    instr_t s;
    s     = nop();
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic step(int i, instr_t s, output bit stalled);
    exp_t e;
    ent_t n;
    bit   busy;
    @(posedge clk);
    #1;
    reset[i]     = s.rst;
    rs_d[i]      = AW'(s.rs);
    rt_d[i]      = AW'(s.rt);
    waddr_d[i]   = AW'(s.waddr);
    tuse_rs_d[i] = TW'(s.tuse_rs);
    tuse_rt_d[i] = TW'(s.tuse_rt);
    tnew_d[i]    = TW'(s.tnew);
    md_op_d[i]   = s.md_op;
    md_div_d[i]  = s.md_div;
    md_use_d[i]  = s.md_use;
    stalled      = 1'b0;
    if (s.rst) begin
      for (int a = 0; a < 3; a++) pipe[i][a] = '{default: 0};
      md_end[i] = -1;
    end else begin
      busy       = cyc[i] <= md_end[i];
      e          = '{default: 0};
      e.cyc      = cyc[i];
      e.md_busy  = busy;
      e.stall    = op_stall(i, s.rs, s.tuse_rs) | op_stall(i, s.rt, s.tuse_rt) |
                   ((s.md_op | s.md_use) & busy);
      if (i == 0) begin
        e.fwd_rs_d = pick(i, s.rs);
        e.fwd_rt_d = pick(i, s.rt);
        e.fwd_rs_e = pick(i, pipe[i][0].rs);
        e.fwd_rt_e = pick(i, pipe[i][0].rt);
        e.fwd_rt_m = hits(i, 2, pipe[i][1].rt) && eff(i, 2) == 0;
      end
      exp_q[i].push_back(e);
      n = '{default: 0};
      if (!e.stall) n = '{v: s.tnew != 0, addr: s.waddr, tnew0: s.tnew, rs: s.rs, rt: s.rt};
      pipe[i][2] = pipe[i][1];
      pipe[i][1] = pipe[i][0];
      pipe[i][0] = n;
      if (!e.stall && s.md_op) md_end[i] = cyc[i] + (s.md_div ? DIV : MUL);
      stalled = e.stall;
    end
    cyc[i]++;
  endtask

  task automatic run(int i);
    bit st;
    int n;
    foreach (prog[k]) begin
      n = 0;
      do begin
        step(i, prog[k], st);
        n++;
      end while (st && prog[k].hold && n < 40);
      if (st && prog[k].hold) begin
        tests++;
        fails++;
        $display("FAIL hold_timeout dut%0d instr %0d still stalled after %0d cycles", i, k, n);
      end
    end
  endtask

  task automatic check(string name, int i, int c, logic [1:0] act, int exp);
    tests++;
    if (act !== 2'(exp)) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, i, c, act, exp);
    end
  endtask

  // Monitor: compares the DUT against whatever the drivers queued this cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (exp_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        check("stall_pc", i, e.cyc, {1'b0, stall_pc[i]}, int'(e.stall));
        check("stall_d",  i, e.cyc, {1'b0, stall_d[i]},  int'(e.stall));
        check("flush_e",  i, e.cyc, {1'b0, flush_e[i]},  int'(e.stall));
        check("md_busy",  i, e.cyc, {1'b0, md_busy[i]},  int'(e.md_busy));
        check("fwd_rs_d", i, e.cyc, fwd_rs_d[i], e.fwd_rs_d);
        check("fwd_rt_d", i, e.cyc, fwd_rt_d[i], e.fwd_rt_d);
        check("fwd_rs_e", i, e.cyc, fwd_rs_e[i], e.fwd_rs_e);
        check("fwd_rt_e", i, e.cyc, fwd_rt_e[i], e.fwd_rt_e);
        check("fwd_rt_m", i, e.cyc, {1'b0, fwd_rt_m[i]}, int'(e.fwd_rt_m));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    instr_t s;
    for (int i = 0; i < 2; i++) begin
      md_end[i] = -1;
      cyc[i]    = 0;
    end
    // Reset, then an idle cycle that observes the reset state.
    prog.push_back(rst_cycle());
    prog.push_back(rst_cycle());
    prog.push_back(nop());
    // lw $1 ; add $6,$1,$2  (load-use)
    prog.push_back(mk(0, 3, 0, 3, 1, 2, 0, 0, 0, 1));
    prog.push_back(mk(1, 1, 2, 1, 6, 1, 0, 0, 0, 1));
    prog.push_back(nop());
    prog.push_back(nop());
    // add $2 ; beq $2,$0
    prog.push_back(mk(7, 1, 8, 1, 2, 1, 0, 0, 0, 1));
    prog.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    prog.push_back(nop());
    prog.push_back(nop());
    // add $3 ; nop ; sw $3 ; lw $4 ; sw $4
    prog.push_back(mk(7, 1, 8, 1, 3, 1, 0, 0, 0, 1));
    prog.push_back(nop());
    prog.push_back(mk(9, 1, 3, 2, 0, 0, 0, 0, 0, 1));
    prog.push_back(mk(9, 1, 0, 3, 4, 2, 0, 0, 0, 1));
    prog.push_back(mk(9, 1, 4, 2, 0, 0, 0, 0, 0, 1));
    prog.push_back(nop());
    prog.push_back(nop());
    // $0 writer never creates a hazard
    prog.push_back(mk(0, 3, 0, 3, 0, 1, 0, 0, 0, 1));
    prog.push_back(mk(0, 1, 0, 1, 5, 1, 0, 0, 0, 1));
    // add $5 ; or using $5
    prog.push_back(mk(7, 1, 8, 1, 5, 1, 0, 0, 0, 1));
    prog.push_back(mk(5, 1, 9, 1, 6, 1, 0, 0, 0, 1));
    // mult ; mflo ; div ; mflo
    prog.push_back(mk(8, 1, 9, 1, 0, 0, 1, 0, 0, 1));
    prog.push_back(mk(0, 3, 0, 3, 10, 1, 0, 0, 1, 1));
    prog.push_back(mk(8, 1, 9, 1, 0, 0, 1, 1, 0, 1));
    prog.push_back(mk(0, 3, 0, 3, 10, 1, 0, 0, 1, 1));
    // div ; mflo stalled for a few cycles ; reset mid-count ; mflo
    prog.push_back(mk(8, 1, 9, 1, 0, 0, 1, 1, 0, 1));
    for (int k = 0; k < 3; k++) prog.push_back(mk(0, 3, 0, 3, 11, 1, 0, 0, 1, 0));
    prog.push_back(rst_cycle());
    prog.push_back(mk(0, 3, 0, 3, 11, 1, 0, 0, 1, 1));
    prog.push_back(nop());
    // Random traffic on a small register set to provoke dense hazards.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        prog.push_back(rst_cycle());
      end else begin
        s = mk($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        prog.push_back(s);
      end
    end
    for (int k = 0; k < 4; k++) prog.push_back(nop());

    fork
      run(0);
      run(1);
    join

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (exp_q[i].size() != 0) begin
        fails++;
        $display("FAIL drain dut%0d: %0d expectations left, expected 0", i, exp_q[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
